// File: rtl/fifo_uart_tx.sv
// Drains a normal-mode FIFO (1-clk read latency) and serialises each byte as an 8N1 frame on txd.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit.
module fifo_uart_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int BAUD_DIV = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdempty,
  input  logic [7:0] q,
  output logic       rdreq,
  output logic       txd,
  output logic       ti,
  output logic       busy
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, STOP} state_t;
`endif

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          rdreq_n, txd_n, ti_n;
  logic          bit_end;
`ifdef UART_TX_PARITY_EN
  logic          par, par_n;
`endif

  assign bit_end = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      rdreq   <= 1'b0;
      txd     <= 1'b1;
      ti      <= 1'b1;
      busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      rdreq   <= rdreq_n;
      txd     <= txd_n;
      ti      <= ti_n;
      busy    <= ~ti_n;
`ifdef UART_TX_PARITY_EN
      par     <= par_n;
`endif
    end
  end

  // txd is loaded one bit ahead: each bit-end edge drives the value for the next line bit.
  always_comb begin
    state_n   = state;
    cnt_n     = '0;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    rdreq_n   = 1'b0;
    txd_n     = txd;
`ifdef UART_TX_PARITY_EN
    par_n     = par;
`endif
    case (state)
      IDLE: begin
        txd_n = 1'b1;
        if (!rdempty) begin
          rdreq_n = 1'b1;
          state_n = REQ;
        end
      end
      REQ: state_n = LOAD;
      LOAD: begin
        shift_n = q;
`ifdef UART_TX_PARITY_EN
        par_n   = ^q;
`endif
        txd_n   = 1'b0;
        state_n = START;
      end
      START: begin
        cnt_n = bit_end ? '0 : cnt + CW'(1);
        if (bit_end) begin
          txd_n     = shift[0];
          bit_idx_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        cnt_n = bit_end ? '0 : cnt + CW'(1);
        if (bit_end) begin
          shift_n   = {1'b0, shift[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            txd_n   = par;
            state_n = PARITY;
`else
            txd_n   = 1'b1;
            state_n = STOP;
`endif
          end else begin
            txd_n = shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        cnt_n = bit_end ? '0 : cnt + CW'(1);
        if (bit_end) begin
          txd_n   = 1'b1;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        cnt_n = bit_end ? '0 : cnt + CW'(1);
        txd_n = 1'b1;
        if (bit_end) state_n = IDLE;
      end
      default: begin
        txd_n   = 1'b1;
        state_n = IDLE;
      end
    endcase
    ti_n = (state_n == IDLE);
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a pointer-based FIFO model feeds the DUT, every output is logged per clock,
// and the txd log is compared cycle by cycle against frames rebuilt from the bytes sent.
module tb_fifo_uart_tx;
  localparam int CLK_FREQ = 50000000;
  localparam int BAUD     = 115200;
  localparam int BD       = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int PERIOD = FB * BD + 3;
  localparam int LOGN   = 131072;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rdempty;
  logic [7:0] q = '0;
  logic       rdreq, txd, ti, busy;

  fifo_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .rdempty(rdempty), .q(q),
    .rdreq(rdreq), .txd(txd), .ti(ti), .busy(busy)
  );

  always #5 clk = ~clk;

  // FIFO model: writes from the stimulus process, reads on rdreq with 1-clk latency
  logic [7:0]  mem [64];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  assign rdempty = (rd_ptr == wr_ptr);

  always @(posedge clk)
    if (rdreq && (rd_ptr != wr_ptr)) begin
      q      <= mem[rd_ptr % 64];
      rd_ptr <= rd_ptr + 1;
    end

  logic txd_log [LOGN];
  logic ti_log [LOGN];
  logic busy_log [LOGN];
  logic rdreq_log [LOGN];
  logic empty_log [LOGN];
  int   cyc = 0;

  always @(negedge clk)
    if (cyc < LOGN) begin
      txd_log[cyc]   <= txd;
      ti_log[cyc]    <= ti;
      busy_log[cyc]  <= busy;
      rdreq_log[cyc] <= rdreq;
      empty_log[cyc] <= rdempty;
      cyc            <= cyc + 1;
    end

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_bytes[$];

  typedef struct {
    int fall, werr, wfirst, pulses, maxw, ti_low, ti_lead, busy_bad, rd_empty;
  } meas_t;

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 64] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  // Reference line level at offset o from the first start bit: frames of FB bits, 3 idle clks between.
  function automatic logic exp_txd(input int o);
    int k, b;
    k = o / PERIOD;
    b = (o % PERIOD) / BD;
    if (k >= exp_bytes.size()) return 1'b1;
    if (b == 0) return 1'b0;
    if (b <= 8) return exp_bytes[k][b-1];
    if (FB == 11 && b == 9) return ^exp_bytes[k];
    return 1'b1;
  endfunction

  function automatic meas_t measure(input int s, input int e);
    meas_t m;
    int run, tf;
    m.fall = -1; m.werr = 0; m.wfirst = -1; m.pulses = 0; m.maxw = 0;
    m.ti_low = 0; m.ti_lead = 0; m.busy_bad = 0; m.rd_empty = 0;
    for (int i = s; i < e; i++)
      if (m.fall < 0 && txd_log[i] == 1'b0) m.fall = i;
    if (m.fall < 0) m.werr = (exp_bytes.size() > 0) ? 9999 : 0;
    else
      for (int i = m.fall; i < e; i++)
        if (txd_log[i] !== exp_txd(i - m.fall)) begin
          m.werr++;
          if (m.wfirst < 0) m.wfirst = i - m.fall;
        end
    run = 0;
    tf = -1;
    for (int i = s; i < e; i++) begin
      if (rdreq_log[i] === 1'b1) begin
        run++;
        if (run == 1) m.pulses++;
        if (run > m.maxw) m.maxw = run;
      end else run = 0;
      if (tf < 0 && ti_log[i] === 1'b0) tf = i;
      if (busy_log[i] !== ~ti_log[i]) m.busy_bad++;
      if (rdreq_log[i] === 1'b1 && empty_log[i] === 1'b1) m.rd_empty++;
    end
    if (tf >= 0) begin
      for (int i = tf; i < e && ti_log[i] === 1'b0; i++) m.ti_low++;
      m.ti_lead = m.fall - tf;
    end
    return m;
  endfunction

  task automatic test_reset();
    meas_t m;
    int s;
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if ({txd, ti, busy, rdreq} !== 4'b1100) begin
      miscompares++;
      $display("FAIL reset_async: {txd,ti,busy,rdreq}=%b expected 1100", {txd, ti, busy, rdreq});
    end
    clks(4);
    rst_n = 1'b1;
    s = cyc;
    exp_bytes = {};
    clks(5000);
    m = measure(s, cyc);
    vectors++;
    if (m.pulses !== 0) begin
      miscompares++;
      $display("FAIL idle_rdreq: %0d rdreq pulses, expected 0", m.pulses);
    end
    vectors++;
    if (m.fall !== -1) begin
      miscompares++;
      $display("FAIL idle_txd: txd low at cycle %0d, expected always high", m.fall);
    end
    vectors++;
    if (m.ti_low !== 0 || m.busy_bad !== 0) begin
      miscompares++;
      $display("FAIL idle_ti_busy: ti low %0d clks, busy errors %0d, expected 0/0", m.ti_low, m.busy_bad);
    end
  endtask

  task automatic test_single(input logic [7:0] b);
    meas_t m;
    int s;
    exp_bytes = {b};
    s = cyc;
    push(b);
    clks(PERIOD + 60);
    m = measure(s, cyc);
    vectors++;
    if (m.werr !== 0) begin
      miscompares++;
      $display("FAIL single_%h_wave: %0d bad clks (first offset %0d), expected 0", b, m.werr, m.wfirst);
    end
    vectors++;
    if (m.pulses !== 1 || m.maxw !== 1) begin
      miscompares++;
      $display("FAIL single_%h_rdreq: %0d pulses max width %0d, expected 1 pulse width 1", b, m.pulses, m.maxw);
    end
    vectors++;
    if (m.ti_low !== FB * BD + 2) begin
      miscompares++;
      $display("FAIL single_%h_ti_low: %0d clks, expected %0d", b, m.ti_low, FB * BD + 2);
    end
    vectors++;
    if (m.ti_lead !== 2) begin
      miscompares++;
      $display("FAIL single_%h_ti_lead: ti fell %0d clks before start bit, expected 2", b, m.ti_lead);
    end
    vectors++;
    if (m.busy_bad !== 0) begin
      miscompares++;
      $display("FAIL single_%h_busy: %0d clks busy != ~ti, expected 0", b, m.busy_bad);
    end
  endtask

  task automatic test_back_to_back(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    meas_t m;
    int s;
    exp_bytes = {b0, b1, b2};
    s = cyc;
    push(b0); push(b1); push(b2);
    clks(3 * PERIOD + 60);
    m = measure(s, cyc);
    vectors++;
    if (m.werr !== 0) begin
      miscompares++;
      $display("FAIL b2b_%h%h%h_wave: %0d bad clks (first offset %0d), expected 0", b0, b1, b2, m.werr, m.wfirst);
    end
    vectors++;
    if (m.pulses !== 3 || m.maxw !== 1) begin
      miscompares++;
      $display("FAIL b2b_rdreq: %0d pulses max width %0d, expected 3 width 1", m.pulses, m.maxw);
    end
    vectors++;
    if (m.rd_empty !== 0 || m.busy_bad !== 0) begin
      miscompares++;
      $display("FAIL b2b_flags: rdreq-while-empty %0d, busy errors %0d, expected 0/0", m.rd_empty, m.busy_bad);
    end
  endtask

  task automatic test_reset_midframe();
    meas_t m;
    int s;
    push(8'h3C);
    push(8'h81);
    clks(3);
    vectors++;
    if (txd !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_start: txd=%b 3 clks after push, expected 0", txd);
    end
    clks(4 * BD + BD / 2);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({txd, ti, busy, rdreq} !== 4'b1100) begin
      miscompares++;
      $display("FAIL midrst_outputs: {txd,ti,busy,rdreq}=%b expected 1100", {txd, ti, busy, rdreq});
    end
    clks(3);
    rst_n = 1'b1;
    exp_bytes = {8'h81};
    s = cyc;
    clks(PERIOD + 60);
    m = measure(s, cyc);
    vectors++;
    if (m.werr !== 0) begin
      miscompares++;
      $display("FAIL midrst_wave: %0d bad clks (first offset %0d), expected 0", m.werr, m.wfirst);
    end
    vectors++;
    if (m.pulses !== 1) begin
      miscompares++;
      $display("FAIL midrst_rdreq: %0d pulses, expected 1", m.pulses);
    end
  endtask

  task automatic test_empty_change();
    meas_t m;
    int s;
    exp_bytes = {8'h5A};
    s = cyc;
    push(8'h5A);
    clks(3);
    vectors++;
    if (txd !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_start: txd=%b 3 clks after push, expected 0", txd);
    end
    clks(3 * BD);
    push(8'h33);
    clks(100);
    if (wr_ptr != rd_ptr) wr_ptr = wr_ptr - 1;
    clks(PERIOD);
    m = measure(s, cyc);
    vectors++;
    if (m.werr !== 0) begin
      miscompares++;
      $display("FAIL empty_wave: %0d bad clks (first offset %0d), expected 0", m.werr, m.wfirst);
    end
    vectors++;
    if (m.pulses !== 1 || m.rd_empty !== 0) begin
      miscompares++;
      $display("FAIL empty_rdreq: %0d pulses, %0d while empty, expected 1/0", m.pulses, m.rd_empty);
    end
    vectors++;
    if ({ti, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL empty_park: {ti,busy}=%b expected 10", {ti, busy});
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity(input logic [7:0] b, input logic p);
    meas_t m;
    int s;
    exp_bytes = {b};
    s = cyc;
    push(b);
    clks(PERIOD + 60);
    m = measure(s, cyc);
    vectors++;
    if (m.werr !== 0 || m.ti_low !== 11 * BD + 2) begin
      miscompares++;
      $display("FAIL parity_%h_frame: %0d bad clks, ti low %0d, expected 0 and %0d", b, m.werr, m.ti_low, 11 * BD + 2);
    end
    vectors++;
    if (m.fall < 0 || txd_log[m.fall + 9 * BD + BD / 2] !== p) begin
      miscompares++;
      $display("FAIL parity_%h_bit: fall %0d parity bit %b, expected %b", b, m.fall,
               (m.fall < 0) ? 1'bx : txd_log[m.fall + 9 * BD + BD / 2], p);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single(8'hA5);
    test_back_to_back(8'h00, 8'hFF, 8'h55);
    test_back_to_back(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)));
    test_reset_midframe();
    test_empty_change();
    test_single(8'($urandom_range(255, 0)));
`ifdef UART_TX_PARITY_EN
    test_parity(8'h07, 1'b1);
    test_parity(8'h03, 1'b0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
